writeback_unit: RTL
===================

# writeback_unit

Writeback queue sitting between the pipeline's result producers (ALU and load unit) and the register file write port. It accepts results over two valid/ready channels, arbitrates them, buffers them in a small in-order FIFO, and drives one registered write per cycle into the register file. It also publishes a per-register pending bitmap that the hazard logic uses to stall dependent reads.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- XLEN, 32: data width.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready at an edge.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- load_valid  in  1  load result valid.
- load_ready  out  1  load handshake ready.
- load_rd  in  5  load destination register.
- load_data  in  XLEN  load result.
- hold  in  1  while high, no entry is dequeued (debug halt / port stolen).
- rf_write_enable  out  1  register-file write strobe (registered).
- rf_write_address  out  5  register-file write address (registered).
- rf_write_data  out  XLEN  register-file write data (registered).
- pending  out  32  bit i = register i has an outstanding write (registered).
- count  out  log2(DEPTH)+1  queue occupancy (registered).

## Operation
- Storage: circular buffer of DEPTH entries {rd, data}, head/tail pointers wrap modulo DEPTH, full when count==DEPTH, empty when count==0.
- Ready: load_ready = !full; alu_ready = !full && !load_valid. Load has fixed priority; at most one enqueue per cycle.
- Ready never depends on same-cycle dequeue; no enqueue while full, even if a dequeue occurs that edge.
- rd==0: handshake completes normally, entry discarded; count, pending and rf outputs unaffected.
- Dequeue: at each edge with !empty && !hold, head entry is popped and loaded into rf_write_address/rf_write_data, rf_write_enable<=1. Otherwise rf_write_enable<=0; address/data hold previous values.
- Enqueue and dequeue in the same edge: count unchanged.
- Order: writes reach the register file strictly in acceptance order, including repeated rd.
- pending: next-state OR of one-hot(rd) over all valid queue entries plus the rf output stage when rf_write_enable is 1. pending[0] always 0. A register written twice stays pending until its last write leaves the output stage.
- Reset (reset==0 at an edge): head=tail=count=0, rf_write_enable=0, rf_write_address=0, rf_write_data=0, pending=0; queued entries discarded. Reset dominates any concurrent handshake. After reset both ready outputs are 1 (alu_ready subject to load_valid).

## Timing
- Handshake at edge E (queue empty, hold low): entry popped at E+1, rf_write_enable high during cycle E+1..E+2, register file captures at E+2.
- pending[rd] rises after E, falls after E+2 (unless another write to rd remains).
- Throughput: one write per cycle sustained; hold stalls dequeue only, enqueue continues until full.
- count updates at the handshake/pop edge; no combinational path from inputs to rf_* or pending.
- Only combinational outputs: alu_ready, load_ready.

## Configuration
- WB_BYPASS_EN defined: when the queue is empty, hold is low and a handshake with rd≠0 occurs at edge E, the entry goes directly into the rf output stage at E (rf_write_enable high during E..E+1, register file captures at E+1). The queue and count are not touched. pending[rd] is set only for the rf output cycle.
- WB_BYPASS_EN undefined: every entry passes through the queue; latency as in Timing.

## Test plan
- Reset, then ALU rd=5 data=0xDEADBEEF -> rf_write_enable=1, address=5, data=0xDEADBEEF in cycle after E+1 (after E with bypass); pending[5] high over exactly that window; count returns to 0.
- Same edge: load rd=4 data=0x44, ALU rd=3 data=0x33 -> load accepted, alu_ready=0; ALU accepted next edge; writes appear 4 then 3 on consecutive cycles.
- hold=1, push 4 ALU entries rd=1..4 -> count=4, both ready=0, 5th valid waits; release hold -> writes rd=1,2,3,4 on four consecutive cycles; 5th accepted the edge after first pop.
- ALU rd=0 data=0xFFFFFFFF -> handshake completes, count stays 0, rf_write_enable stays 0, pending=0.
- rd=7 data=1 then rd=7 data=2 -> writes 1 then 2 in order; pending[7] stays high continuously until the second write cycle ends.
- 3 entries queued, hold=1, reset=0 for one edge with load_valid=1 -> count=0, rf_write_enable=0, pending=0, load not accepted; no writes after reset released.

Source files
------------

// File: rtl/writeback_unit_if.sv
// Writeback channel bundle: the ALU and load-unit result producers plus the
// registered register-file write port. The master modport is the producer /
// register-file side; the slave modport is the writeback unit itself.
interface writeback_unit_if #(
  parameter int XLEN = 32
);
  // ALU result channel
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  // Load result channel
  logic            load_valid;
  logic            load_ready;
  logic [4:0]      load_rd;
  logic [XLEN-1:0] load_data;

  // Register-file write port
  logic            rf_write_enable;
  logic [4:0]      rf_write_address;
  logic [XLEN-1:0] rf_write_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output load_valid, load_rd, load_data,
    input  alu_ready, load_ready,
    input  rf_write_enable, rf_write_address, rf_write_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  load_valid, load_rd, load_data,
    output alu_ready, load_ready,
    output rf_write_enable, rf_write_address, rf_write_data
  );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: in-order writeback queue between the ALU / load unit and the
// register-file write port. Load has fixed priority over ALU, at most one
// result is accepted per cycle, one registered write leaves per cycle, and a
// per-register pending bitmap is published for hazard detection.
//
// Optional feature: define WB_BYPASS_EN to let a result skip the queue and go
// straight into the write stage when the queue is empty and hold is low.
// Without it every result passes through the queue.
//
// DEPTH must be a power of two and at least 2 (pointers wrap by overflow).
module writeback_unit #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clock,
  input  logic                   reset,   // synchronous, active low
  input  logic                   hold,
  writeback_unit_if.slave        wb,
  output logic [31:0]            pending,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  // Queue bookkeeping. Destination registers live in flops because every
  // slot feeds the pending bitmap; data lives in an inferred RAM.
  logic [AW-1:0]   head_reg, head_next;
  logic [AW-1:0]   tail_reg, tail_next;
  logic [AW:0]     count_reg, count_next;
  logic [DEPTH-1:0] slot_valid_reg, slot_valid_next;
  logic [4:0]      slot_rd_reg  [DEPTH];
  logic [4:0]      slot_rd_next [DEPTH];
  logic [XLEN-1:0] data_mem     [DEPTH];

  // Register-file output stage
  logic            rf_en_reg, rf_en_next;
  logic [4:0]      rf_addr_reg, rf_addr_next;
  logic [XLEN-1:0] rf_data_reg;
  logic [31:0]     pending_reg, pending_next;

  // Handshake / control
  logic            full;
  logic            empty;
  logic            load_fire;
  logic            alu_fire;
  logic            in_fire;
  logic            in_write;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_data;
  logic            deq;
  logic            enq;
  logic            bypass;
  logic [31:0]     slot_mask [DEPTH];

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

  // Ready is a function of registered occupancy only, never of a same-cycle pop.
  assign wb.load_ready = !full;
  assign wb.alu_ready  = !full && !wb.load_valid;

  assign load_fire = wb.load_valid && !full;
  assign alu_fire  = wb.alu_valid && !full && !wb.load_valid;
  assign in_fire   = load_fire || alu_fire;
  assign in_rd     = load_fire ? wb.load_rd   : wb.alu_rd;
  assign in_data   = load_fire ? wb.load_data : wb.alu_data;

  // Writes to x0 complete the handshake but are dropped here.
  assign in_write  = in_fire && (in_rd != 5'd0);
  assign deq       = !empty && !hold;

`ifdef WB_BYPASS_EN
  // Empty queue and no hold: nothing can be ahead of this result, so it may
  // enter the write stage directly without breaking ordering.
  assign bypass = in_write && empty && !hold;
`else
  assign bypass = 1'b0;
`endif

  assign enq = in_write && !bypass;

  // Next-state for queue pointers, occupancy, slot tags and the write stage.
  always_comb begin
    head_next       = head_reg;
    tail_next       = tail_reg;
    count_next      = count_reg;
    slot_valid_next = slot_valid_reg;
    for (int i = 0; i < DEPTH; i++) begin
      slot_rd_next[i] = slot_rd_reg[i];
    end
    rf_en_next   = 1'b0;
    rf_addr_next = rf_addr_reg;

    // enq and deq never touch the same slot: that would need tail==head,
    // which only happens when empty (no deq) or full (no enq).
    if (enq) begin
      tail_next                 = tail_reg + 1'b1;
      slot_valid_next[tail_reg] = 1'b1;
      slot_rd_next[tail_reg]    = in_rd;
    end
    if (deq) begin
      head_next                 = head_reg + 1'b1;
      slot_valid_next[head_reg] = 1'b0;
    end

    case ({enq, deq})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    if (deq) begin
      rf_en_next   = 1'b1;
      rf_addr_next = slot_rd_reg[head_reg];
    end else if (bypass) begin
      rf_en_next   = 1'b1;
      rf_addr_next = in_rd;
    end
  end

  // One-hot contribution of each slot as it will look after this edge.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_mask
      assign slot_mask[gi] = slot_valid_next[gi] ? (32'd1 << slot_rd_next[gi]) : 32'd0;
    end
  endgenerate

  // Pending bitmap from next state so it is a clean register with no input-to-output path.
  always_comb begin
    pending_next = rf_en_next ? (32'd1 << rf_addr_next) : 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_next = pending_next | slot_mask[i];
    end
    pending_next[0] = 1'b0;
  end

  // Control and tag state; reset clears everything and wins over any handshake.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      slot_valid_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_rd_reg[i] <= 5'd0;
      end
      rf_en_reg      <= 1'b0;
      rf_addr_reg    <= 5'd0;
      pending_reg    <= 32'd0;
    end else begin
      head_reg       <= head_next;
      tail_reg       <= tail_next;
      count_reg      <= count_next;
      slot_valid_reg <= slot_valid_next;
      for (int i = 0; i < DEPTH; i++) begin
        slot_rd_reg[i] <= slot_rd_next[i];
      end
      rf_en_reg      <= rf_en_next;
      rf_addr_reg    <= rf_addr_next;
      pending_reg    <= pending_next;
    end
  end

  // Data RAM write port; stale contents are harmless because slot_valid gates use.
  always_ff @(posedge clock) begin
    if (enq && reset) begin
      data_mem[tail_reg] <= in_data;
    end
  end

  // Registered RAM read straight into the write-data stage (or the bypass path).
  always_ff @(posedge clock) begin
    if (!reset) begin
      rf_data_reg <= '0;
    end else if (deq) begin
      rf_data_reg <= data_mem[head_reg];
    end else if (bypass) begin
      rf_data_reg <= in_data;
    end
  end

  assign wb.rf_write_enable  = rf_en_reg;
  assign wb.rf_write_address = rf_addr_reg;
  assign wb.rf_write_data    = rf_data_reg;
  assign pending             = pending_reg;
  assign count               = count_reg;

endmodule
